booth_multiplier_r4: RTL and testbench
======================================

# booth_multiplier_r4

Parametrised sequential radix-4 Booth multiplier for the datapath's MUL instruction, generalising the fixed 32-bit radix-2 multiplier. It adds a selectable signed/unsigned mode, a start/busy/done handshake and a fixed latency of roughly half the radix-2 iteration count. It sits beside the ALU. The control unit pulses `start`, waits for `done`, and writes `product` into the HI/LO register pair.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be even and ≥ 4.
- `clk`  in  1  system clock; all state changes occur on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request pulse; sampled only in IDLE or DONE.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; captured with `start`.
- `multiplicand`  in  WIDTH  operand M; captured with `start`.
- `multiplier`  in  WIDTH  operand Q; captured with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle completion pulse.
- `product`  out  2*WIDTH  result; holds its value until the next completion.

## Operation
- **Operand extension:** both operands are extended to E = WIDTH+2 bits, sign-extended if `is_signed`, else zero-extended. One datapath therefore serves both modes. Iteration count N = E/2 = WIDTH/2+1.
- **Registers:**
  - accumulator A, E+2 bits, holds up to ±2M without overflow;
  - Q register, E bits;
  - guard bit q₋₁;
  - extended multiplicand M, E bits;
  - iteration counter, $clog2(N+1) bits.
- **Load:** A=0, Q=ext(multiplier), q₋₁=0, M=ext(multiplicand), count=0.
- **Iteration:** the triplet {Q[1],Q[0],q₋₁} selects digit 0, +M, +M, +2M, −2M, −M, −M, 0 for 000…111.
  - A += digit, computed in E+2 bits; −M and −2M are formed as two's complement.
  - {A,Q,q₋₁} is then shifted arithmetic-right by 2 and count is incremented.
- **Result:** after N iterations, `product` = the low 2*WIDTH bits of {A,Q}. The value is exact for every operand pair in both modes.
- **States:**
  - IDLE: `start`=1 → load, go to RUN.
  - RUN: one iteration per cycle. On the N-th iteration, register the result into `product` and go to DONE.
  - DONE: `done`=1. `start`=1 → load and go to RUN (back-to-back); else go to IDLE.
- `start` asserted during RUN is ignored. The operation in progress is not disturbed.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- **Reset values:** `clr` forces state=IDLE and `busy`=0, `done`=0, `product`=0, with all internal registers 0. It takes effect immediately and asynchronously, including mid-RUN; the partial result is discarded.
- **Latency:** with `start` accepted at edge 0, iterations occur at edges 1..N. `product` updates and `done` rises at edge N, and `done` falls at edge N+1. For WIDTH=32, `done` is high in the 17th cycle after the start edge.
- **`busy` timing:** high from edge 0 to edge N, low in IDLE and DONE.
- **Throughput:** one result per N+1 cycles using back-to-back `start` in DONE.
- **Outputs:** registered; no combinational path from inputs to outputs.

## Structure
- **Package `mul_pkg`:**
  - state enum {IDLE, RUN, DONE};
  - Booth digit select encoding {ZERO, PM, P2M, NM, N2M};
  - a function returning N for a given WIDTH.
- **Sub-module `booth_r4_encoder`:** combinational. Takes the 3-bit triplet and produces the digit select. It is instantiated once and verified standalone against the 8-entry mapping.
- **Top module:** FSM, counter, E+2-bit adder/subtractor and shift register.

## Test plan
- **Signed small operands:** WIDTH=32, signed, −7 × 3 → `product`=0xFFFF_FFFF_FFFF_FFEB; `done` exactly 17 cycles after the start edge; `busy` high for the intervening cycles.
- **Mode sensitivity:** operands 0xFFFFFFFF × 0xFFFFFFFF:
  - unsigned → 0xFFFF_FFFE_0000_0001;
  - signed → 0x0000_0000_0000_0001.
- **Extreme signed operands:** signed 0x80000000 × 0x80000000 → 0x4000_0000_0000_0000. Signed 0x7FFFFFFF × 0x80000000 → 0xC000_0000_8000_0000.
- **Back-to-back and ignored start:**
  - `start` held high through two operations (5×6, then 9×−1) → 30, then 0xFFFF_FFFF_FFFF_FFF7;
  - second `done` 18 cycles after the first;
  - `start` pulsed mid-RUN has no effect.
- **Reset mid-operation:** `clr` asserted at iteration 8 → `busy`, `done` and `product` are 0 immediately. A fresh 12 × 12 issued after release returns 144.
- **Randomised sweep:** 10k random operand/mode pairs at WIDTH=8, 16 and 32, compared against a reference model. Zero operands, ±1, and `is_signed` toggling between consecutive operations are included.

Source files
------------

// File: rtl/booth_multiplier_r4_pkg.sv
// booth_multiplier_r4_pkg: shared state/digit encodings and iteration-count helper
package booth_multiplier_r4_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {ZERO, PM, P2M, NM, N2M} digit_e;
  function automatic int n_iter(input int width);
    return width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_multiplier_r4_if.sv
// booth_multiplier_r4_if: start/busy/done handshake and operand/result bus
interface booth_multiplier_r4_if #(parameter int WIDTH = 32);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  modport master(output start, is_signed, multiplicand, multiplier, input busy, done, product);
  modport slave(input start, is_signed, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/booth_multiplier_r4_encoder.sv
// booth_multiplier_r4_encoder: maps the {q1,q0,q-1} triplet to a radix-4 Booth digit
module booth_multiplier_r4_encoder
  import booth_multiplier_r4_pkg::*;
(
  input  logic [2:0] trip_i,
  output digit_e     dig_o
);
  // 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M, 000/111 -> 0
  always_comb begin
    dig_o = (trip_i == 3'b011) ? P2M :
            (trip_i == 3'b100) ? N2M :
            (trip_i == 3'b001 || trip_i == 3'b010) ? PM :
            (trip_i == 3'b101 || trip_i == 3'b110) ? NM : ZERO;
  end
endmodule

// File: rtl/booth_multiplier_r4.sv
// booth_multiplier_r4: sequential radix-4 Booth multiplier, signed/unsigned, start/busy/done
module booth_multiplier_r4
  import booth_multiplier_r4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  clr,
  booth_multiplier_r4_if.slave bus
);
  localparam int E  = WIDTH + 2;
  localparam int AW = E + 2;
  localparam int N  = n_iter(WIDTH);
  localparam int CW = $clog2(N + 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [E-1:0]       q_q, q_d;
  logic [E-1:0]       m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  digit_e             dig;
  logic [AW-1:0]      mext, addend, sum, a_n;
  logic [E-1:0]       q_n, m_ext, q_ext;
  logic               load;

  booth_multiplier_r4_encoder u_enc (
    .trip_i({q_q[1:0], qm1_q}),
    .dig_o (dig)
  );

  // one Booth step: add the selected digit, then shift {A,Q,q-1} right by two
  always_comb begin
    mext   = {{2{m_q[E-1]}}, m_q};
    addend = (dig == PM)  ? mext :
             (dig == P2M) ? (mext << 1) :
             (dig == NM)  ? -mext :
             (dig == N2M) ? -(mext << 1) : '0;
    sum    = a_q + addend;
    a_n    = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_n    = {sum[1:0], q_q[E-1:2]};
    m_ext  = bus.is_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand} : {2'b00, bus.multiplicand};
    q_ext  = bus.is_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier} : {2'b00, bus.multiplier};
  end

  // control: accept start outside RUN, iterate N times, publish result and pulse done
  always_comb begin
    load    = bus.start && (state_q != RUN);
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (load) begin
      state_d = RUN;
      a_d     = '0;
      q_d     = q_ext;
      m_d     = m_ext;
      qm1_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = a_n;
      q_d   = q_n;
      qm1_d = q_q[1];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d = DONE;
        prod_d  = {a_n[WIDTH-3:0], q_n};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // state and datapath registers; clr discards any operation in flight
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_multiplier_r4.sv
// tb_booth_multiplier_r4: directed and swept checks of the radix-4 Booth multiplier at WIDTH=32 and 8
module tb_booth_multiplier_r4;
  import booth_multiplier_r4_pkg::*;
  localparam int NA = 17;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic clr_b = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   b_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_multiplier_r4_if #(.WIDTH(32)) ia();
  booth_multiplier_r4_if #(.WIDTH(8))  ib();
  booth_multiplier_r4 #(.WIDTH(32)) dut_a (.clk(clk), .clr(clr),   .bus(ia));
  booth_multiplier_r4 #(.WIDTH(8))  dut_b (.clk(clk), .clr(clr_b), .bus(ib));

  logic [2:0] trip = 3'd0;
  digit_e     dig;
  booth_multiplier_r4_encoder u_enc (.trip_i(trip), .dig_o(dig));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference products from plain integer arithmetic on the operand values
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(x * y);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'({24'd0, a});
    y = s ? int'($signed(b)) : int'({24'd0, b});
    return 16'(x * y);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'hFF;
      3: return 8'h80;
      4: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // behavioural model: an accepted request completes N cycles later with the reference product
  int          ma_left = 0;
  logic        ma_done = 1'b0;
  logic [63:0] ma_prod = '0, ma_pend = '0;
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      ma_left <= 0;
      ma_done <= 1'b0;
      ma_prod <= '0;
      ma_pend <= '0;
    end else begin
      ma_done <= 1'b0;
      if (ma_left == 0 && ia.start) begin
        ma_left <= NA;
        ma_pend <= ref32(ia.multiplicand, ia.multiplier, ia.is_signed);
      end else if (ma_left > 0) begin
        ma_left <= ma_left - 1;
        if (ma_left == 1) begin
          ma_done <= 1'b1;
          ma_prod <= ma_pend;
        end
      end
    end
  end

  int          mb_left = 0;
  logic        mb_done = 1'b0;
  logic [15:0] mb_prod = '0, mb_pend = '0;
  always @(posedge clk or posedge clr_b) begin
    if (clr_b) begin
      mb_left <= 0;
      mb_done <= 1'b0;
      mb_prod <= '0;
      mb_pend <= '0;
    end else begin
      mb_done <= 1'b0;
      if (mb_left == 0 && ib.start) begin
        mb_left <= NB;
        mb_pend <= ref8(ib.multiplicand, ib.multiplier, ib.is_signed);
      end else if (mb_left > 0) begin
        mb_left <= mb_left - 1;
        if (mb_left == 1) begin
          mb_done <= 1'b1;
          mb_prod <= mb_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a_busy", 64'(ia.busy), 64'(ma_left > 0));
    chk("a_done", 64'(ia.done), 64'(ma_done));
    chk("a_product", ia.product, ma_prod);
    chk("b_busy", 64'(ib.busy), 64'(mb_left > 0));
    chk("b_done", 64'(ib.done), 64'(mb_done));
    chk("b_product", 64'(ib.product), 64'(mb_prod));
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int t0);
    @(posedge clk);
    #2;
    ia.start = 1'b1;
    ia.multiplicand = a;
    ia.multiplier = b;
    ia.is_signed = s;
    @(posedge clk);
    #2;
    t0 = cyc;
    ia.start = 1'b0;
    ia.multiplicand = $urandom;
    ia.multiplier = $urandom;
    ia.is_signed = 1'($urandom);
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ia.done) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] exp, input string nm);
    int t0, t1;
    start_op(a, b, s, t0);
    wait_done(t1);
    chk({nm, "_latency"}, 64'(t1 - t0), 64'(NA));
    chk({nm, "_product"}, ia.product, exp);
  endtask

  initial begin
    int t0, t1, t2;
    logic [31:0] a, b;
    logic s;
    ia.start = 1'b0;
    ia.is_signed = 1'b0;
    ia.multiplicand = '0;
    ia.multiplier = '0;
    #1 clr = 1'b1;
    begin
      digit_e enc_exp [8] = '{ZERO, PM, PM, P2M, N2M, NM, NM, ZERO};
      for (int t = 0; t < 8; t++) begin
        trip = 3'(t);
        #1;
        chk($sformatf("encoder_%0d", t), 64'(dig), 64'(enc_exp[t]));
      end
    end
    chk("model_m7x3", ref32(32'hFFFF_FFF9, 32'd3, 1'b1), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model8_min", 64'(ref8(8'h80, 8'h80, 1'b1)), 64'h4000);
    @(negedge clk);
    chk("reset_busy", 64'(ia.busy), 64'd0);
    chk("reset_done", 64'(ia.done), 64'd0);
    chk("reset_product", ia.product, 64'd0);
    @(posedge clk);
    #2 clr = 1'b0;
    op32(32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "m7x3");
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "ones_unsigned");
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "ones_signed");
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "min_x_min");
    op32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "max_x_min");
    @(posedge clk);
    #2;
    ia.start = 1'b1;
    ia.multiplicand = 32'd5;
    ia.multiplier = 32'd6;
    ia.is_signed = 1'b1;
    @(posedge clk);
    #2;
    t0 = cyc;
    ia.multiplicand = 32'd9;
    ia.multiplier = 32'hFFFF_FFFF;
    wait_done(t1);
    chk("b2b_first_latency", 64'(t1 - t0), 64'(NA));
    chk("b2b_first_product", ia.product, 64'd30);
    @(posedge clk);
    #2 ia.start = 1'b0;
    wait_done(t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'(NA + 1));
    chk("b2b_second_product", ia.product, 64'hFFFF_FFFF_FFFF_FFF7);
    start_op(32'd100, 32'd7, 1'b0, t0);
    repeat (5) @(posedge clk);
    #2;
    ia.start = 1'b1;
    ia.multiplicand = 32'd1;
    ia.multiplier = 32'd1;
    @(posedge clk);
    #2 ia.start = 1'b0;
    wait_done(t1);
    chk("ignored_start_latency", 64'(t1 - t0), 64'(NA));
    chk("ignored_start_product", ia.product, 64'd700);
    repeat (2) @(negedge clk);
    chk("ignored_start_idle", 64'(ia.busy), 64'd0);
    start_op(32'd123, 32'd456, 1'b0, t0);
    repeat (9) @(negedge clk);
    #1 clr = 1'b1;
    #1;
    chk("clr_busy", 64'(ia.busy), 64'd0);
    chk("clr_done", 64'(ia.done), 64'd0);
    chk("clr_product", ia.product, 64'd0);
    @(posedge clk);
    #2 clr = 1'b0;
    op32(32'd12, 32'd12, 1'b0, 64'd144, "after_clr");
    for (int i = 0; i < 150; i++) begin
      a = pick32();
      b = pick32();
      s = (i % 2 == 1) ^ ($urandom_range(0, 3) == 0);
      op32(a, b, s, ref32(a, b, s), "sweep32");
    end
    for (int k = 0; k < 20000 && !b_done; k++) @(posedge clk);
    chk("sweep8_finished", 64'(b_done), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int t0, t1;
    logic [7:0] a, b;
    logic s;
    logic [7:0]  lit_a [3] = '{8'h80, 8'hFF, 8'hFF};
    logic [7:0]  lit_b [3] = '{8'h80, 8'hFF, 8'hFF};
    logic        lit_s [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] lit_p [3] = '{16'h4000, 16'hFE01, 16'h0001};
    ib.start = 1'b0;
    ib.is_signed = 1'b0;
    ib.multiplicand = '0;
    ib.multiplier = '0;
    #1 clr_b = 1'b1;
    repeat (2) @(posedge clk);
    #2 clr_b = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      a = (i < 3) ? lit_a[i] : pick8();
      b = (i < 3) ? lit_b[i] : pick8();
      s = (i < 3) ? lit_s[i] : ((i % 2 == 1) ^ ($urandom_range(0, 3) == 0));
      @(posedge clk);
      #2;
      ib.start = 1'b1;
      ib.multiplicand = a;
      ib.multiplier = b;
      ib.is_signed = s;
      @(posedge clk);
      #2;
      t0 = cyc;
      ib.start = 1'b0;
      ib.multiplicand = 8'($urandom);
      ib.multiplier = 8'($urandom);
      t1 = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ib.done) begin
          t1 = cyc;
          break;
        end
      end
      chk("sweep8_latency", 64'(t1 - t0), 64'(NB));
      if (i < 3) chk($sformatf("w8_literal_%0d", i), 64'(ib.product), 64'(lit_p[i]));
    end
    b_done = 1'b1;
  end
endmodule
